dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer in front of `data_memory`. It shares the single memory port between the processor load/store unit (port 0) and the image-streaming engine (port 1). Port 0 has fixed priority, with a starvation bound that protects port 1. It also range-checks and alignment-checks every access, and returns exactly one tagged response per granted access, aligned to the memory's one-cycle registered read.

## Interface
Parameters:
- `NUM_WORDS`, 10: number of 32-bit words implemented in `data_memory`.
- `MAX_WAIT`, 4: consecutive cycles port 1 may be refused before it is forced to win. Must be ≥ 1.

Ports (`P` ∈ {0,1}):
- `clk`  in  1  single clock. Memory reads on posedge and writes on negedge of this same clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pP_req`  in  1  access request.
- `pP_we`  in  1  1 = write, 0 = read.
- `pP_addr`  in  32  byte address.
- `pP_wdata`  in  32  write data.
- `pP_gnt`  out  1  request accepted this cycle (combinational).
- `pP_rvalid`  out  1  response for this port's previously granted access.
- `pP_rdata`  out  32  read data; valid only while `pP_rvalid` is high.
- `pP_err`  out  1  granted access was misaligned or out of range; valid only while `pP_rvalid` is high.
- `mem_write`  out  1  to `data_memory.mem_write`.
- `mem_address`  out  32  to `data_memory.address`.
- `mem_write_data`  out  32  to `data_memory.write_data`.
- `mem_read_data`  in  32  from `data_memory.read_data`.

## Operation
- Handshake: a requester holds `req`, `we`, `addr` and `wdata` stable from the cycle it raises `req` until the cycle in which `gnt` is high. `gnt` completes the transfer in that cycle. A requester may present a new request in the following cycle.
- At most one `gnt` per cycle. Grant rule:
  - Port 1 wins if `p1_req` is high and `wait_cnt == MAX_WAIT`.
  - Otherwise port 0 wins if `p0_req` is high.
  - Otherwise port 1 wins if `p1_req` is high.
- `wait_cnt`, width `$clog2(MAX_WAIT+1)`:
  - Increments (saturating at `MAX_WAIT`) in each cycle where `p1_req` is high and port 1 is not granted.
  - Clears to 0 when port 1 is granted or when `p1_req` is low.
- Access check: an access is legal iff `addr[1:0]==0` and `addr[31:2] < NUM_WORDS`.
- Memory drive during a granted cycle:
  - `mem_address` = winner's `addr`.
  - `mem_write_data` = winner's `wdata`.
  - `mem_write` = winner's `we` AND legal.
- Memory drive with no grant: `mem_write` = 0, `mem_address` = 0, `mem_write_data` = 0.
- An illegal access never writes the memory.
- Response pipeline: `rsp_valid`, `rsp_port`, `rsp_err` and `rsp_we` are registered from the grant.
  - `pP_rvalid` = `rsp_valid && rsp_port==P`.
  - `pP_err` = `rsp_err` while `pP_rvalid` is high.
  - `pP_rdata` = `mem_read_data` for a legal read; 0 for a write or an illegal access; 0 while `pP_rvalid` is low.
- Every grant produces exactly one response, for writes as well as reads.
- Back-to-back grants are allowed, to the same port or alternating ports. Throughput is one access per cycle.
- Reset (`rst_n` low, at any time): `wait_cnt` = 0 and `rsp_valid` = 0, so any in-flight response is discarded. All outputs read 0 while `rst_n` is low.

## Timing
- Cycle N: `gnt` and the `mem_*` signals are combinational from the requests and the registered `wait_cnt`.
  - A write lands in the memory at the negedge in the middle of cycle N.
  - A read address is sampled by the memory at the posedge that ends cycle N.
- Cycle N+1: `rvalid`, `rdata` and `err` are presented for exactly one cycle. Fixed latency is 1, with no stall path.
- Read-after-write to the same word in consecutive cycles (write in N, read in N+1) returns the new data, because the negedge write precedes the read posedge.
- Simultaneous requests when `wait_cnt < MAX_WAIT`: port 0 granted, port 1 refused, `wait_cnt` increments.
- Reset values of all outputs: 0.

## Structure
- `dmem_pkg` holds:
  - `typedef enum logic {PORT_CPU=1'b0, PORT_IMG=1'b1} port_e`.
  - `typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} dmem_req_t`.
  - `localparam` defaults for `NUM_WORDS` and `MAX_WAIT`.
- No sub-module. The range/alignment check is a local function. The arbiter is one `always_comb` plus one `always_ff` with async clear.

## Test plan
- Reset: hold `rst_n`=0 with both requests active → all outputs 0. Release → first grant goes to port 0.
- Single read: port 0 reads `addr`=0x8 with `RAM[2]`=0xDEADBEEF → `p0_gnt` in N; `p0_rvalid`=1, `p0_rdata`=0xDEADBEEF, `p0_err`=0 in N+1.
- Write then read: port 1 writes 0x12345678 to 0x4 in N, then reads 0x4 in N+1 → `p1_rdata`=0x12345678 in N+2.
- Illegal accesses: write to 0x28 (index 10) and read from 0x6 → `mem_write`=0 in both grant cycles; responses carry `err`=1, `rdata`=0; memory contents unchanged.
- Starvation: both ports request continuously with `MAX_WAIT`=4 → port 0 is granted 4 cycles, port 1 in the 5th, then the pattern repeats; `wait_cnt` never exceeds 4.
- Reset mid-operation: assert `rst_n` low in the cycle after a read grant → no `rvalid` appears, `wait_cnt` is 0 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared types and default sizing for the data-memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic {PORT_CPU = 1'b0, PORT_IMG = 1'b1} port_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    localparam int unsigned c_NUM_WORDS_DEFAULT = 10;
    localparam int unsigned c_MAX_WAIT_DEFAULT  = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Two-port fixed-priority arbiter with starvation bound in front of
//          data_memory; range/alignment check and one tagged response per grant.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_WORDS = c_NUM_WORDS_DEFAULT,
    parameter int unsigned MAX_WAIT  = c_MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned       c_WCW      = $clog2(MAX_WAIT + 1);
    localparam logic [c_WCW-1:0] c_WAIT_MAX = c_WCW'(MAX_WAIT);

    function automatic logic f_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(NUM_WORDS));
    endfunction

    logic [c_WCW-1:0] r_wait_cnt;
    logic             r_rsp_valid;
    port_e            r_rsp_port;
    logic             r_rsp_err;
    logic             r_rsp_we;

    dmem_req_t w_req0;
    dmem_req_t w_req1;
    dmem_req_t w_win;
    logic      w_gnt0;
    logic      w_gnt1;
    logic      w_any;
    logic      w_legal;

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        w_req0  = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
        w_req1  = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        if (rst_n) begin
            if (p1_req && (r_wait_cnt == c_WAIT_MAX)) begin
                w_gnt1 = 1'b1;
            end else if (p0_req) begin
                w_gnt0 = 1'b1;
            end else if (p1_req) begin
                w_gnt1 = 1'b1;
            end
        end
        w_any          = w_gnt0 | w_gnt1;
        w_win          = w_gnt1 ? w_req1 : w_req0;
        w_legal        = f_legal(w_win.addr);
        mem_write      = w_any && w_win.we && w_legal;
        mem_address    = w_any ? w_win.addr  : 32'h0;
        mem_write_data = w_any ? w_win.wdata : 32'h0;
    end

    assign p0_gnt = w_gnt0;
    assign p1_gnt = w_gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= PORT_CPU;
            r_rsp_err   <= 1'b0;
            r_rsp_we    <= 1'b0;
        end else begin
            r_rsp_valid <= w_any;
            r_rsp_port  <= w_gnt1 ? PORT_IMG : PORT_CPU;
            r_rsp_err   <= !w_legal;
            r_rsp_we    <= w_win.we;
            if (p1_req && !w_gnt1) begin
                if (r_wait_cnt != c_WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + c_WCW'(1);
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Read data passes straight from the memory's registered output.
    assign p0_rvalid = r_rsp_valid && (r_rsp_port == PORT_CPU);
    assign p1_rvalid = r_rsp_valid && (r_rsp_port == PORT_IMG);
    assign p0_err    = p0_rvalid && r_rsp_err;
    assign p1_err    = p1_rvalid && r_rsp_err;
    assign p0_rdata  = (p0_rvalid && !r_rsp_err && !r_rsp_we) ? mem_read_data : 32'h0;
    assign p1_rdata  = (p1_rvalid && !r_rsp_err && !r_rsp_we) ? mem_read_data : 32'h0;

endmodule

`default_nettype wire
